less_seq_ctrl: RTL

LESS_SEQ_CTRL -- requirements
Module: less_seq_ctrl

---
 rtl/less_seq_pkg.sv | 15 +
 rtl/less_eq_chunk.sv | 14 +
 rtl/less_seq_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/less_seq_pkg.sv
// Shared types and helpers for the sequential chunked unsigned less-than comparator.
package less_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Number of CHUNK-wide slices needed to cover WIDTH bits (ceiling division).
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/less_eq_chunk.sv
// Combinational single-slice comparator: unsigned x < y and x == y.
module less_eq_chunk #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             lt,
  output logic             eq
);

  assign lt = (x < y);
  assign eq = (x == y);

endmodule

// File: rtl/less_seq_ctrl.sv
// Sequential unsigned a<b / a==b comparator: walks CHUNK-wide slices MSB-first,
// stopping at the first differing slice, with valid/ready handshakes on both sides.
module less_seq_ctrl
  import less_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  output logic             out_eq
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  state_e           r_state, w_state_d;
  logic [PW-1:0]    r_a, r_b, w_a_ext, w_b_ext;
  logic [IDXW-1:0]  r_idx, w_idx_d;
  logic             r_out, w_out_d;
  logic             r_eq, w_eq_d;
  logic             w_load;
  logic [CHUNK-1:0] w_xa, w_xb;
  logic             w_slice_lt, w_slice_eq;

  // Zero-extend operands to a whole number of slices.
  always_comb begin
    w_a_ext = '0;
    w_b_ext = '0;
    w_a_ext[WIDTH-1:0] = a;
    w_b_ext[WIDTH-1:0] = b;
  end

  assign w_xa = r_a[r_idx*CHUNK +: CHUNK];
  assign w_xb = r_b[r_idx*CHUNK +: CHUNK];

  less_eq_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x  (w_xa),
    .y  (w_xb),
    .lt (w_slice_lt),
    .eq (w_slice_eq)
  );

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_out_d   = r_out;
    w_eq_d    = r_eq;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load    = 1'b1;
          w_idx_d   = IDX_TOP;
          w_state_d = RUN;
        end
      end
      RUN: begin
        if (!w_slice_eq) begin
          // First differing slice from the top decides the result.
          w_out_d   = w_slice_lt;
          w_eq_d    = 1'b0;
          w_state_d = DONE;
        end else if (r_idx == '0) begin
          w_out_d   = 1'b0;
          w_eq_d    = 1'b1;
          w_state_d = DONE;
        end else begin
          w_idx_d = r_idx - IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_out   <= 1'b0;
      r_eq    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_out   <= w_out_d;
      r_eq    <= w_eq_d;
      if (w_load) begin
        r_a <= w_a_ext;
        r_b <= w_b_ext;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign out_eq    = r_eq;

endmodule
